tinuc_dbus_responder: RTL and testbench

//  Responder end of the TinuC data bus (daddr/ddata_w/ddata_r/d_rw). Decodes the core's

---
 rtl/tinuc_bus_pkg.sv | 15 +
 rtl/tinuc_dbus_responder_if.sv | 10 +
 rtl/tinuc_uart_tx.sv | 76 +++++++
 rtl/tinuc_dbus_responder.sv | 99 +++++++++
 tb/tb_tinuc_dbus_responder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/tinuc_bus_pkg.sv
// Shared constants and types for the TinuC data-bus responder.
package tinuc_bus_pkg;

  localparam logic [9:0] ADDR_GPIO_OUT  = 10'h200;
  localparam logic [9:0] ADDR_GPIO_IN   = 10'h204;
  localparam logic [9:0] ADDR_CYCLE_CNT = 10'h208;
  localparam logic [9:0] ADDR_UART_TX   = 10'h20C;
  localparam logic [9:0] ADDR_UART_STAT = 10'h210;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_OVR_BIT  = 1;

  typedef enum logic [1:0] {UTX_IDLE, UTX_START, UTX_DATA, UTX_STOP} utx_state_t;

endpackage

// File: rtl/tinuc_dbus_responder_if.sv
// Core-side data bus: the core is master, the responder is slave.
interface tinuc_dbus_responder_if;
  logic [9:0]  daddr;
  logic [31:0] ddata_w;
  logic        d_rw;
  logic [31:0] ddata_r;

  modport master (output daddr, ddata_w, d_rw, input ddata_r);
  modport slave  (input daddr, ddata_w, d_rw, output ddata_r);
endinterface

// File: rtl/tinuc_uart_tx.sv
// 8N1 UART transmitter; each symbol lasts exactly CLKS_PER_BIT cycles.
module tinuc_uart_tx
  import tinuc_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_TOP = CW'(CLKS_PER_BIT - 1);

  utx_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shr_q, shr_d;

  // start_i is ignored outside IDLE; the top flags that case as overrun
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shr_d   = shr_q;
    if (state_q == UTX_IDLE) begin
      if (start_i) begin
        state_d = UTX_START;
        cnt_d   = CNT_TOP;
        bit_d   = '0;
        shr_d   = data_i;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = CNT_TOP;
      case (state_q)
        UTX_START: state_d = UTX_DATA;
        UTX_DATA: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = UTX_STOP;
        end
        default:   state_d = UTX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= UTX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
    end
  end

  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      UTX_START: tx_o = 1'b0;
      UTX_DATA:  tx_o = shr_q[bit_q];
      default:   tx_o = 1'b1;
    endcase
  end

  assign busy_o = (state_q != UTX_IDLE);

endmodule

// File: rtl/tinuc_dbus_responder.sv
// TinuC data-bus responder: word RAM below 0x200, GPIO / cycle counter / UART above.
module tinuc_dbus_responder
  import tinuc_bus_pkg::*;
#(
  parameter int RAM_WORDS    = 128,
  parameter int CLKS_PER_BIT = 434,
  parameter int GPIO_W       = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  tinuc_dbus_responder_if.slave   dbus,
  input  logic [GPIO_W-1:0]       gpio_in,
  output logic [GPIO_W-1:0]       gpio_out,
  output logic                    uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]       mem [RAM_WORDS];
  logic [AW-1:0]     ram_idx;
  logic [9:0]        waddr;
  logic              wr_ram, wr_gpio, wr_cnt, wr_tx, wr_stat;
  logic [GPIO_W-1:0] gpio_q, gpio_d, sync1_q, sync2_q;
  logic [31:0]       cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic              busy;
  logic [31:0]       rdata;
  logic              unused_addr_bits;

  assign waddr   = {dbus.daddr[9:2], 2'b00};
  assign ram_idx = dbus.daddr[2 +: AW];
  assign unused_addr_bits = ^dbus.daddr[1:0];

  assign wr_ram  = dbus.d_rw & ~dbus.daddr[9];
  assign wr_gpio = dbus.d_rw & (waddr == ADDR_GPIO_OUT);
  assign wr_cnt  = dbus.d_rw & (waddr == ADDR_CYCLE_CNT);
  assign wr_tx   = dbus.d_rw & (waddr == ADDR_UART_TX);
  assign wr_stat = dbus.d_rw & (waddr == ADDR_UART_STAT);

  always_ff @(posedge CLK) begin
    if (wr_ram) mem[ram_idx] <= dbus.ddata_w;
  end

  always_comb begin
    gpio_d = wr_gpio ? dbus.ddata_w[GPIO_W-1:0] : gpio_q;
    cnt_d  = wr_cnt ? dbus.ddata_w : cnt_q + 32'd1;
    ovr_d  = ovr_q;
    if (wr_tx && busy) ovr_d = 1'b1;
    if (wr_stat && dbus.ddata_w[STAT_OVR_BIT]) ovr_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      gpio_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  tinuc_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .start_i (wr_tx),
    .data_i  (dbus.ddata_w[7:0]),
    .busy_o  (busy),
    .tx_o    (uart_tx)
  );

  // Pure decode: reads have no side effects and track daddr in the same cycle
  always_comb begin
    rdata = '0;
    if (!dbus.daddr[9]) begin
      rdata = mem[ram_idx];
    end else begin
      case (waddr)
        ADDR_GPIO_OUT:  rdata[GPIO_W-1:0] = gpio_q;
        ADDR_GPIO_IN:   rdata[GPIO_W-1:0] = sync2_q;
        ADDR_CYCLE_CNT: rdata = cnt_q;
        ADDR_UART_STAT: begin
          rdata[STAT_BUSY_BIT] = busy;
          rdata[STAT_OVR_BIT]  = ovr_q;
        end
        default:        rdata = '0;
      endcase
    end
  end

  assign dbus.ddata_r = rdata;
  assign gpio_out     = gpio_q;

endmodule

// File: tb/tb_tinuc_dbus_responder.sv
// Directed and randomized checks of the data-bus responder against a cycle-level model.
module tb_tinuc_dbus_responder;

  localparam int CPB = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] gpio_in = '0;
  logic [7:0] gpio_out;
  logic       uart_tx;

  tinuc_dbus_responder_if bus();

  tinuc_dbus_responder #(.RAM_WORDS(128), .CLKS_PER_BIT(CPB), .GPIO_W(8)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .dbus     (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .uart_tx  (uart_tx)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_ram [128];
  bit          m_ok  [128];
  logic [31:0] m_cnt;
  logic [7:0]  m_gpio, m_s1, m_s2;
  bit          m_ovr, m_busy;
  bit          m_tx = 1'b1;
  bit          fq[$];   // line level for every remaining cycle of the frame

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(logic [9:0] a);
    logic [9:0] wa;
    wa = {a[9:2], 2'b00};
    if (!a[9]) return m_ram[a[8:2]];
    case (wa)
      10'h200: return {24'b0, m_gpio};
      10'h204: return {24'b0, m_s2};
      10'h208: return m_cnt;
      10'h210: return {30'b0, m_ovr, m_busy};
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model with the inputs presented this cycle, then clock the DUT
  task automatic tick();
    logic [9:0] wa;
    logic [9:0] fr;
    wa = {bus.daddr[9:2], 2'b00};
    if (RESET) begin
      m_cnt = '0; m_gpio = '0; m_s1 = '0; m_s2 = '0; m_ovr = 1'b0;
      fq.delete();
    end else begin
      m_s2 = m_s1;
      m_s1 = gpio_in;
      if (bus.d_rw && wa == 10'h208) m_cnt = bus.ddata_w;
      else m_cnt = m_cnt + 32'd1;
      if (bus.d_rw) begin
        if (!bus.daddr[9]) begin
          m_ram[bus.daddr[8:2]] = bus.ddata_w;
          m_ok[bus.daddr[8:2]]  = 1'b1;
        end
        if (wa == 10'h200) m_gpio = bus.ddata_w[7:0];
        if (wa == 10'h20C) begin
          if (m_busy) m_ovr = 1'b1;
          else begin
            fr = {1'b1, bus.ddata_w[7:0], 1'b0};
            for (int k = 0; k < 10; k++)
              for (int j = 0; j < CPB; j++) fq.push_back(fr[k]);
          end
        end
        if (wa == 10'h210 && bus.ddata_w[1]) m_ovr = 1'b0;
      end
    end
    if (fq.size() > 0) begin m_tx = fq.pop_front(); m_busy = 1'b1; end
    else begin m_tx = 1'b1; m_busy = 1'b0; end
    @(posedge CLK);
    #1;
    chk("uart_tx_model", uart_tx, m_tx);
    chk("gpio_out_model", gpio_out, m_gpio);
  endtask

  task automatic rdchk(string tag, logic [9:0] a, logic [31:0] exp);
    bus.daddr = a;
    bus.d_rw  = 1'b0;
    #1;
    chk(tag, bus.ddata_r, exp);
  endtask

  task automatic wr(logic [9:0] a, logic [31:0] d);
    bus.daddr   = a;
    bus.ddata_w = d;
    bus.d_rw    = 1'b1;
    tick();
    bus.d_rw    = 1'b0;
  endtask

  initial begin
    logic [9:0]  seq;
    logic [9:0]  a;
    logic [31:0] d;
    logic [6:0]  idx;
    logic        rw;
    int          r;

    seq = 10'b1101001010;  // 0xA5 frame, index k = k-th symbol on the line
    bus.daddr = '0; bus.ddata_w = '0; bus.d_rw = 1'b0;
    for (int i = 0; i < 128; i++) m_ok[i] = 1'b0;

    // Reset
    RESET = 1'b1; tick(); tick(); RESET = 1'b0;
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_uart_tx", uart_tx, 32'h1);
    rdchk("rst_cnt", 10'h208, 32'h0);
    rdchk("rst_status", 10'h210, 32'h0);
    tick();
    rdchk("cnt_after_rst", 10'h208, 32'h1);

    // RAM
    wr(10'h004, 32'hDEADBEEF);
    rdchk("ram_004", 10'h004, 32'hDEADBEEF);
    wr(10'h1FC, 32'h12345678);
    wr(10'h000, 32'hCAFEF00D);
    rdchk("ram_1fc", 10'h1FC, 32'h12345678);
    rdchk("ram_000", 10'h000, 32'hCAFEF00D);
    tick();
    rdchk("ram_004_byteoff", 10'h007, 32'hDEADBEEF);

    // Counter wrap
    wr(10'h208, 32'hFFFFFFFE);
    rdchk("cnt_w0", 10'h208, 32'hFFFFFFFE);
    tick(); rdchk("cnt_w1", 10'h208, 32'hFFFFFFFF);
    tick(); rdchk("cnt_w2", 10'h208, 32'h00000000);

    // UART frame
    wr(10'h20C, 32'h000000A5);
    for (int k = 0; k < 10 * CPB; k++) begin
      chk("frame_tx", uart_tx, seq[k / CPB]);
      rdchk("frame_busy", 10'h210, 32'h1);
      tick();
    end
    rdchk("frame_idle", 10'h210, 32'h0);
    chk("frame_idle_tx", uart_tx, 32'h1);

    // Overrun, sticky, clear by w1c
    wr(10'h20C, 32'h000000A5);
    for (int k = 0; k < 10 * CPB; k++) begin
      chk("ovr_frame_tx", uart_tx, seq[k / CPB]);
      if (k == 11) rdchk("ovr_set", 10'h210, 32'h3);
      if (k == 16) rdchk("ovr_sticky", 10'h210, 32'h3);
      if (k == 21) rdchk("ovr_clear", 10'h210, 32'h1);
      if (k == 10) begin bus.daddr = 10'h20C; bus.ddata_w = 32'h3C; bus.d_rw = 1'b1; end
      if (k == 15) begin bus.daddr = 10'h210; bus.ddata_w = 32'h0;  bus.d_rw = 1'b1; end
      if (k == 20) begin bus.daddr = 10'h210; bus.ddata_w = 32'h2;  bus.d_rw = 1'b1; end
      tick();
      bus.d_rw = 1'b0;
    end
    rdchk("ovr_done", 10'h210, 32'h0);

    // GPIO
    gpio_in = 8'h5A;
    tick(); rdchk("gpio_in_1edge", 10'h204, 32'h0);
    tick(); rdchk("gpio_in_2edge", 10'h204, 32'h5A);
    wr(10'h200, 32'h000001C3);
    rdchk("gpio_out_rd", 10'h200, 32'hC3);
    rdchk("txdata_rd", 10'h20C, 32'h0);
    rdchk("unmapped_rd", 10'h3F0, 32'h0);

    // Reset in the middle of a frame
    wr(10'h20C, 32'h000000FF);
    for (int k = 0; k < 12; k++) tick();
    rdchk("mid_busy", 10'h210, 32'h1);
    RESET = 1'b1; tick(); RESET = 1'b0;
    chk("mid_rst_tx", uart_tx, 32'h1);
    chk("mid_rst_gpio", gpio_out, 32'h0);
    rdchk("mid_rst_status", 10'h210, 32'h0);
    rdchk("mid_rst_gpio_in", 10'h204, 32'h0);
    rdchk("mid_rst_ram", 10'h004, 32'hDEADBEEF);
    tick();
    chk("mid_rst_tx2", uart_tx, 32'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      r   = $urandom_range(0, 99);
      d   = $urandom;
      idx = ($urandom_range(0, 3) == 0) ? 7'd127 : 7'($urandom_range(0, 5));
      if (r < 40)      a = {1'b0, idx, 2'($urandom)};
      else if (r < 45) a = 10'h3F4;
      else             a = {1'b1, 4'b0000, 3'($urandom_range(0, 4)), 2'($urandom)};
      rw = ($urandom_range(0, 2) == 0);
      if (rw && a[9] && a[4:2] == 3'd3 && $urandom_range(0, 1) == 0) rw = 1'b0;
      if (rw && a[9] && a[4:2] == 3'd2 && $urandom_range(0, 1) == 0)
        d = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) gpio_in = 8'($urandom);
      bus.daddr = a; bus.ddata_w = d; bus.d_rw = rw;
      #1;
      if (a[9] || m_ok[a[8:2]]) chk("rand_read", bus.ddata_r, mread(a));
      tick();
    end
    bus.d_rw = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
